score_text_gen: RTL and testbench

Character and glyph source for the end-of-game text overlay. It keeps the player score, converts it to decimal with a sequential shift-add-3 converter, and maps each character cell address from the overlay drawer to an ASCII code. It fetches the glyph row from the 8x8 font ROM and returns a 40-pixel row (each font pixel scaled 5x) exactly two pclk cycles after the cell address. It sits directly upstream of the overlay drawer, which owns the 560x240 text box made of 14x6 cells of 40x40 pixels.

---
 rtl/score_text_gen.sv | 114 +++++++++++
 tb/tb_score_text_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/score_text_gen.sv
// score_text_gen: score counter, sequential BCD converter and character/glyph source for the end-of-game overlay.
module score_text_gen #(
    parameter int SCORE_MAX     = 9999,
    parameter int TXT_ROW_TITLE = 0,
    parameter int TXT_ROW_SCORE = 2,
    parameter int TXT_ROW_HINT  = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        apple_eaten,
    input  logic        score_clear,
    input  logic        game_over,
    input  logic        victory,
    input  logic [7:0]  char_yx,
    input  logic [7:0]  char_line,
    input  logic [7:0]  font_row,
    output logic [9:0]  font_addr,
    output logic [39:0] char_pixels,
    output logic [13:0] score,
    output logic        conv_busy
);
    localparam logic [71:0] TXT_GO = "GAME OVER";
    localparam logic [55:0] TXT_YW = "YOU WIN";
    localparam logic [39:0] TXT_SC = "SCORE";
    localparam logic [87:0] TXT_PR = "PRESS RESET";
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t      state;
    logic        pending, inc, change;
    logic [13:0] bin;
    logic [15:0] bcd, bcd_adj, digits;
    logic [3:0]  cnt, cx, cy;
    logic [7:0]  ascii;
    logic [2:0]  glyph_row;
    logic        zero_sup, blank, blank_q1, blank_q2;
    assign inc    = apple_eaten && score != 14'(SCORE_MAX);
    assign change = score_clear || inc;
    assign {cy, cx} = char_yx;
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // Pending is re-armed by any change, even one landing in the cycle a conversion starts.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            score     <= '0;
            pending   <= 1'b0;
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            digits    <= '0;
            conv_busy <= 1'b0;
        end else begin
            score   <= score_clear ? 14'd0 : inc ? score + 14'd1 : score;
            pending <= change || (pending && state != IDLE);
            case (state)
                IDLE: if (pending) begin
                    bin       <= score;
                    bcd       <= '0;
                    cnt       <= '0;
                    state     <= SHIFT;
                    conv_busy <= 1'b1;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    cnt        <= cnt + 4'd1;
                    if (cnt == 4'd13) state <= COMMIT;
                end
                default: begin
                    digits    <= bcd;
                    state     <= IDLE;
                    conv_busy <= 1'b0;
                end
            endcase
        end
    end
    // Suppressed leading zeros keep their digit code but are blanked like spaces.
    always_comb begin
        ascii    = 8'h20;
        zero_sup = 1'b0;
        if (cx < 4'd14 && cy < 4'd6) begin
            if (cy == 4'(TXT_ROW_TITLE)) begin
                if (game_over && cx >= 4'd2 && cx <= 4'd10) ascii = TXT_GO[8*(10-int'(cx)) +: 8];
                else if (!game_over && victory && cx >= 4'd3 && cx <= 4'd9) ascii = TXT_YW[8*(9-int'(cx)) +: 8];
            end else if (cy == 4'(TXT_ROW_SCORE)) begin
                if (cx >= 4'd2 && cx <= 4'd6) ascii = TXT_SC[8*(6-int'(cx)) +: 8];
                else if (cx >= 4'd8 && cx <= 4'd11) begin
                    ascii    = {4'h3, digits[4*(11-int'(cx)) +: 4]};
                    zero_sup = (cx == 4'd8 && digits[15:12] == 4'd0) || (cx == 4'd9 && digits[15:8] == 8'd0)
                            || (cx == 4'd10 && digits[15:4] == 12'd0);
                end
            end else if (cy == 4'(TXT_ROW_HINT) && cx >= 4'd1 && cx <= 4'd11) ascii = TXT_PR[8*(11-int'(cx)) +: 8];
        end
    end
    assign blank     = zero_sup || ascii == 8'h20;
    assign glyph_row = char_line >= 8'd40 ? 3'd7 : 3'(char_line / 8'd5);
    // Second blank stage lines up with the font ROM's one-cycle read latency.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            font_addr <= '0;
            blank_q1  <= 1'b1;
            blank_q2  <= 1'b1;
        end else begin
            font_addr <= {ascii[6:0], glyph_row};
            blank_q1  <= blank;
            blank_q2  <= blank_q1;
        end
    end
    always_comb begin
        char_pixels = '0;
        for (int i = 0; i < 8; i++) char_pixels[5*i +: 5] = {5{font_row[i] & ~blank_q2}};
    end
endmodule

// File: tb/tb_score_text_gen.sv
// tb_score_text_gen: table-driven scoreboard bench for score_text_gen with a registered font ROM model.
module tb_score_text_gen;
    logic        pclk = 0, rst = 1, apple_eaten = 0, score_clear = 0, game_over = 0, victory = 0;
    logic [7:0]  char_yx = 0, char_line = 0, font_row = 0;
    logic [9:0]  font_addr;
    logic [39:0] char_pixels;
    logic [13:0] score;
    logic        conv_busy;
    logic        fix_en = 0, drv_valid = 0;
    logic [7:0]  fix_val = 0;
    logic [1:0]  vld = 0;
    int          errors = 0, checks = 0;
    logic [9:0]  qa[$];
    logic [39:0] qp[$];
    typedef struct {
        logic       go, vic;
        logic [7:0] yx, line;
        logic [6:0] asc;
        logic [2:0] row;
        logic       blank;
    } vec_t;
    vec_t v_zero[5], v_123[10], v_title[12];

    score_text_gen dut (.pclk(pclk), .rst(rst), .apple_eaten(apple_eaten), .score_clear(score_clear),
        .game_over(game_over), .victory(victory), .char_yx(char_yx), .char_line(char_line),
        .font_row(font_row), .font_addr(font_addr), .char_pixels(char_pixels), .score(score),
        .conv_busy(conv_busy));

    always #5 pclk = ~pclk;

    function automatic logic [7:0] rom_f(input logic [9:0] a);
        return fix_en ? fix_val : (a[7:0] ^ {a[9:8], 6'h25});
    endfunction
    function automatic logic [39:0] expand(input logic [7:0] b);
        logic [39:0] r = '0;
        for (int i = 0; i < 8; i++) r[5*i +: 5] = {5{b[i]}};
        return r;
    endfunction
    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge pclk) font_row <= rom_f(font_addr);
    always @(posedge pclk) vld <= {vld[0], drv_valid};
    always @(negedge pclk) begin
        if (vld[0]) begin
            if (qa.size() == 0) chk("font_addr_queue", 1, 0);
            else chk("font_addr", 40'(font_addr), 40'(qa.pop_front()));
        end
        if (vld[1]) begin
            if (qp.size() == 0) chk("char_pixels_queue", 1, 0);
            else chk("char_pixels", char_pixels, qp.pop_front());
        end
    end

    task automatic apply(input vec_t v);
        logic [9:0] ea;
        @(negedge pclk);
        game_over = v.go; victory = v.vic; char_yx = v.yx; char_line = v.line; drv_valid = 1;
        ea = {v.asc, v.row};
        qa.push_back(ea);
        qp.push_back(v.blank ? 40'd0 : expand(rom_f(ea)));
    endtask
    task automatic drain;
        @(negedge pclk) drv_valid = 0;
        repeat (3) @(negedge pclk);
    endtask
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            apple_eaten = 1;
        end
        @(negedge pclk) apple_eaten = 0;
    endtask
    task automatic clear_and_settle;
        @(negedge pclk) score_clear = 1;
        @(negedge pclk) score_clear = 0;
        repeat (40) @(negedge pclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v_zero = '{'{0,0,8'h28,8'd0,7'h30,3'd0,1}, '{0,0,8'h29,8'd5,7'h30,3'd1,1},
                   '{0,0,8'h2A,8'd12,7'h30,3'd2,1}, '{0,0,8'h2B,8'd39,7'h30,3'd7,0},
                   '{0,0,8'h22,8'd45,7'h53,3'd7,0}};
        v_123  = '{'{0,0,8'h28,8'd0,7'h30,3'd0,1}, '{0,0,8'h29,8'd10,7'h31,3'd2,0},
                   '{0,0,8'h2A,8'd20,7'h32,3'd4,0}, '{0,0,8'h2B,8'd30,7'h33,3'd6,0},
                   '{0,0,8'h26,8'd4,7'h45,3'd0,0},  '{0,0,8'h27,8'd0,7'h20,3'd0,1},
                   '{0,0,8'h41,8'd0,7'h50,3'd0,0},  '{0,0,8'h4B,8'd0,7'h54,3'd0,0},
                   '{0,0,8'h4C,8'd0,7'h20,3'd0,1},  '{0,0,8'h2C,8'd0,7'h20,3'd0,1}};
        v_title = '{'{0,1,8'h03,8'd0,7'h59,3'd0,0}, '{0,1,8'h09,8'd0,7'h4E,3'd0,0},
                    '{0,1,8'h02,8'd0,7'h20,3'd0,1}, '{0,1,8'h06,8'd0,7'h20,3'd0,1},
                    '{0,1,8'h07,8'd0,7'h57,3'd0,0}, '{1,1,8'h02,8'd0,7'h47,3'd0,0},
                    '{1,1,8'h0A,8'd0,7'h52,3'd0,0}, '{1,1,8'h06,8'd0,7'h20,3'd0,1},
                    '{1,0,8'h07,8'd35,7'h4F,3'd7,0}, '{0,0,8'h05,8'd0,7'h20,3'd0,1},
                    '{1,0,8'h0F,8'd0,7'h20,3'd0,1}, '{1,0,8'h70,8'd0,7'h20,3'd0,1}};
        repeat (3) @(negedge pclk);
        chk("rst_font_addr", 40'(font_addr), 0);
        chk("rst_char_pixels", char_pixels, 0);
        chk("rst_score", 40'(score), 0);
        chk("rst_conv_busy", 40'(conv_busy), 0);
        rst = 0;
        repeat (20) @(negedge pclk);
        foreach (v_zero[i]) apply(v_zero[i]);
        drain();

        pulses(123);
        repeat (40) @(negedge pclk);
        chk("score_123", 40'(score), 123);
        chk("busy_idle_123", 40'(conv_busy), 0);
        foreach (v_123[i]) apply(v_123[i]);
        drain();
        foreach (v_title[i]) apply(v_title[i]);
        drain();

        fix_en = 1; fix_val = 8'h81;
        @(negedge pclk) game_over = 1; victory = 0; char_yx = 8'h02; char_line = 0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("fixed_font_addr", 40'(font_addr), 40'({7'h47, 3'd0}));
        chk("fixed_pixels", char_pixels, 40'hF80000001F);
        fix_en = 0; game_over = 0;

        @(negedge pclk) apple_eaten = 1; score_clear = 1;
        @(negedge pclk) apple_eaten = 0; score_clear = 0;
        chk("clear_priority", 40'(score), 0);
        repeat (40) @(negedge pclk);

        pulses(9998);
        chk("score_9998", 40'(score), 9998);
        pulses(3);
        chk("score_sat", 40'(score), 9999);
        repeat (40) @(negedge pclk);
        chk("busy_idle_sat", 40'(conv_busy), 0);
        for (int c = 8; c < 12; c++) apply('{0, 0, 8'(8'h20 + c), 8'd0, 7'h39, 3'd0, 0});
        drain();

        clear_and_settle();
        pulses(1);
        repeat (5) @(negedge pclk);
        chk("busy_mid_conv", 40'(conv_busy), 1);
        pulses(1);
        repeat (50) @(negedge pclk);
        chk("score_2", 40'(score), 2);
        chk("busy_idle_2", 40'(conv_busy), 0);
        apply('{0, 0, 8'h2B, 8'd0, 7'h32, 3'd0, 0});
        apply('{0, 0, 8'h2A, 8'd0, 7'h30, 3'd0, 1});
        drain();

        pulses(1);
        repeat (5) @(negedge pclk);
        rst = 1;
        #1;
        chk("abort_score", 40'(score), 0);
        chk("abort_busy", 40'(conv_busy), 0);
        chk("abort_font_addr", 40'(font_addr), 0);
        @(negedge pclk) rst = 0;
        apply('{0, 0, 8'h2B, 8'd0, 7'h30, 3'd0, 0});
        apply('{0, 0, 8'h29, 8'd0, 7'h30, 3'd0, 1});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
